rr_grant_arbiter8: RTL and testbench

//   Round-robin arbiter sharing one resource among 8 requesters.

---
 rtl/rr_grant_arbiter8.sv | 125 ++++++++++++
 tb/tb_rr_grant_arbiter8.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter: 8 requesters share one resource, with an optional hold timeout.
// Ports:
//   clk, rst (sync, active-high), req[7:0]
//   grant[7:0] one-hot, grant_idx[2:0], grant_valid, timeout (1-cycle pulse), busy
module rr_grant_arbiter8 #(
    parameter int HOLD_W   = 16,
    parameter int MAX_HOLD = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    // Last hold count before a forced release; unused when MAX_HOLD is 0.
    localparam int                HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_LAST_I[HOLD_W-1:0];
    localparam logic              HOLD_EN     = (MAX_HOLD != 0);

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]        grant_q, grant_d;
    logic [2:0]        grant_idx_q, grant_idx_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       owner_drop;
    logic       hold_expired;

    // Scan ptr+1, ptr+2, ... wrapping; the last winner (ptr) is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        owner_drop   = !req[grant_idx_q];
        hold_expired = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d     = ST_GRANT;
                    grant_d     = 8'b1 << win_idx;
                    grant_idx_d = win_idx;
                    valid_d     = 1'b1;
                    ptr_d       = win_idx;
                    hold_cnt_d  = '0;
                end
            end
            ST_GRANT: begin
                if (owner_drop || hold_expired) begin
                    state_d     = ST_IDLE;
                    grant_d     = 8'd0;
                    grant_idx_d = 3'd0;
                    valid_d     = 1'b0;
                    // A voluntary drop wins over an expiry in the same cycle.
                    timeout_d   = !owner_drop;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd7;
            hold_cnt_q  <= '0;
            grant_q     <= 8'd0;
            grant_idx_q <= 3'd0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;
    assign busy        = valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// Bench for rr_grant_arbiter8: directed stimulus pushes expected grants,
// a negedge monitor pops and compares them as grants appear and end.
module tb_rr_grant_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;
    logic       busy;

    rr_grant_arbiter8 #(
        .HOLD_W  (16),
        .MAX_HOLD(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int idx, input int len, input int to);
        exp_t e;
        e.idx = idx;
        e.len = len;
        e.to  = to;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: grant start pops an expectation; grant end checks length and timeout.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_grant;
        int         run_len;
        exp_t       cur;
        prev_valid = 1'b0;
        prev_grant = 8'd0;
        run_len    = 0;
        cur.idx    = 0;
        cur.len    = 0;
        cur.to     = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (grant_valid) begin
                    if (!prev_valid) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_grant", 32'(grant_idx), -1);
                            cur.idx = 32'(grant_idx);
                            cur.len = 0;
                            cur.to  = 0;
                        end else begin
                            cur = exp_q.pop_front();
                            chk("grant_idx", 32'(grant_idx), cur.idx);
                            chk("grant_vec", 32'(grant), 32'(1) << cur.idx);
                        end
                        run_len = 1;
                    end else begin
                        run_len++;
                        chk("grant_stable", 32'(grant), 32'(prev_grant));
                    end
                    chk("busy_in_grant", 32'(busy), 1);
                    chk("timeout_in_grant", 32'(timeout), 0);
                end else begin
                    if (prev_valid) begin
                        chk("hold_len", run_len, cur.len);
                        chk("timeout_at_release", 32'(timeout), cur.to);
                    end else begin
                        chk("timeout_idle", 32'(timeout), 0);
                    end
                    chk("grant_idle", 32'(grant), 0);
                    chk("grant_idx_idle", 32'(grant_idx), 0);
                    chk("busy_idle", 32'(busy), 0);
                end
                prev_valid = grant_valid;
                prev_grant = grant;
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Idle after reset: nothing must be granted.
        tick(5);

        // All requesting: 0..7 then 0, each held 3 cycles with one idle gap.
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            int b;
            b = k % 8;
            push(b, 3, 0);
            tick(1);
            tick(2);
            req[b] = 1'b0;
            tick(1);
            if (k < 8) req[b] = 1'b1;
            else req = 8'h00;
        end
        tick(2);

        // Make 2 the last winner, then 7 beats 1, then 1.
        push(2, 2, 0);
        req = 8'h04;
        tick(2);
        push(7, 2, 0);
        req = 8'h82;
        tick(3);
        push(1, 2, 0);
        req = 8'h02;
        tick(3);
        req = 8'h00;
        tick(3);

        // Hold timeout with a single persistent requester.
        push(0, 4, 1);
        push(0, 2, 0);
        req = 8'h01;
        tick(7);
        req = 8'h00;
        tick(3);

        // Reset mid-grant; ptr must return to 7 so 0 beats 7 afterwards.
        push(4, 2, 0);
        req = 8'h10;
        tick(2);
        rst = 1'b1;
        req = 8'h00;
        tick(1);
        rst = 1'b0;
        push(0, 2, 0);
        req = 8'h81;
        tick(2);
        req = 8'h00;
        tick(3);

        // Owner 3 drops as requester 5 rises.
        push(3, 2, 0);
        req = 8'h08;
        tick(2);
        push(5, 2, 0);
        req = 8'h20;
        tick(3);
        req = 8'h00;
        tick(4);

        chk("pending_expectations", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
